// File: rtl/reg_scoreboard.sv
// Per-register pending-writer scoreboard for decode RAW/WAW interlock.
// Counts issued-but-not-retired writers per GPR plus total in-flight instructions.
module reg_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2,
  parameter int INF_W = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wen,
  input  logic [4:0]       id_wdest,
  input  logic             id_fire,
  input  logic             wb_valid,
  input  logic             wb_wen,
  input  logic [4:0]       wb_wdest,
  input  logic             flush,
  output logic             rs_wait,
  output logic             rt_wait,
  output logic             waw_full,
  output logic             id_stall,
  output logic [INF_W-1:0] inflight,
  output logic             sb_err
);

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] CONE = CNT_W'(1);
  localparam logic [INF_W-1:0] IMAX = '1;
  localparam logic [INF_W-1:0] IONE = INF_W'(1);

  logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [INF_W-1:0]           inf_q, inf_d;
  logic                       err_q, err_d;

  logic fire, iss, ret, same;

  // cnt_q[0] is never written, so r0 reads as "no writers" by construction
  assign rs_wait  = id_valid & id_use_rs & (id_rs != 5'd0) & (cnt_q[id_rs] != '0);
  assign rt_wait  = id_valid & id_use_rt & (id_rt != 5'd0) & (cnt_q[id_rt] != '0);
  assign waw_full = id_valid & id_wen & (id_wdest != 5'd0) & (cnt_q[id_wdest] == CMAX);
  assign id_stall = rs_wait | rt_wait | waw_full;
  assign inflight = inf_q;
  assign sb_err   = err_q;

  assign fire = id_fire & id_valid;
  assign iss  = fire & id_wen & (id_wdest != 5'd0);
  assign ret  = wb_valid & wb_wen & (wb_wdest != 5'd0);
  assign same = iss & ret & (id_wdest == wb_wdest);

  always_comb begin
    cnt_d = cnt_q;
    inf_d = inf_q;
    err_d = err_q;
    if (flush) begin
      cnt_d = '0;
      inf_d = '0;
    end else begin
      if (id_fire & ~id_valid) err_d = 1'b1;
      if (fire & id_stall)     err_d = 1'b1;
      // issue+retire to one register cancel out, even at the counter limits
      if (!same) begin
        if (iss) begin
          if (cnt_q[id_wdest] == CMAX) err_d = 1'b1;
          else cnt_d[id_wdest] = cnt_q[id_wdest] + CONE;
        end
        if (ret) begin
          if (cnt_q[wb_wdest] == '0) err_d = 1'b1;
          else cnt_d[wb_wdest] = cnt_q[wb_wdest] - CONE;
        end
      end
      case ({fire, wb_valid})
        2'b10: if (inf_q == IMAX) err_d = 1'b1; else inf_d = inf_q + IONE;
        2'b01: if (inf_q == '0)   err_d = 1'b1; else inf_d = inf_q - IONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      inf_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      inf_q <= inf_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed spec scenarios plus randomized pipeline traffic checked against
// an integer per-register writer-count model.
module tb_reg_scoreboard;
  logic       clk, resetn;
  logic       id_valid, id_use_rs, id_use_rt, id_wen, id_fire;
  logic [4:0] id_rs, id_rt, id_wdest;
  logic       wb_valid, wb_wen, flush;
  logic [4:0] wb_wdest;
  logic       rs_wait, rt_wait, waw_full, id_stall, sb_err;
  logic [2:0] inflight;

  int n_chk = 0, n_fail = 0;

  int m_cnt[32];
  int m_inf;
  bit m_err;
  int q[$];  // dest of each in-flight instruction (-1 = no write), oldest first

  reg_scoreboard dut (
    .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wen(id_wen), .id_wdest(id_wdest),
    .id_fire(id_fire), .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_wdest(wb_wdest),
    .flush(flush), .rs_wait(rs_wait), .rt_wait(rt_wait), .waw_full(waw_full),
    .id_stall(id_stall), .inflight(inflight), .sb_err(sb_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic bit e_rs();
    return id_valid && id_use_rs && id_rs != 0 && m_cnt[id_rs] != 0;
  endfunction
  function automatic bit e_rt();
    return id_valid && id_use_rt && id_rt != 0 && m_cnt[id_rt] != 0;
  endfunction
  function automatic bit e_waw();
    return id_valid && id_wen && id_wdest != 0 && m_cnt[id_wdest] == 3;
  endfunction

  task automatic model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_inf = 0; m_err = 0; q.delete();
  endtask

  // Next model state from the current inputs, evaluated just before the edge.
  task automatic model_step();
    bit ok_fire, issue, retire;
    int n;
    ok_fire = id_fire && id_valid;
    if (flush) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_inf = 0;
      return;
    end
    if (id_fire && !id_valid) m_err = 1;
    if (ok_fire && (e_rs() || e_rt() || e_waw())) m_err = 1;
    issue  = ok_fire && id_wen && id_wdest != 0;
    retire = wb_valid && wb_wen && wb_wdest != 0;
    if (!(issue && retire && id_wdest == wb_wdest)) begin
      if (issue)  begin if (m_cnt[id_wdest] == 3) m_err = 1; else m_cnt[id_wdest]++; end
      if (retire) begin if (m_cnt[wb_wdest] == 0) m_err = 1; else m_cnt[wb_wdest]--; end
    end
    n = m_inf + int'(ok_fire) - int'(wb_valid);
    if (n < 0 || n > 7) m_err = 1; else m_inf = n;
  endtask

  task automatic cyc();
    if (resetn) model_step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_wen = 0; id_wdest = 0; id_fire = 0;
    wb_valid = 0; wb_wen = 0; wb_wdest = 0; flush = 0;
  endtask

  task automatic issue_set(input logic [4:0] d);
    id_valid = 1; id_wen = 1; id_wdest = d; id_fire = 1;
  endtask

  task automatic retire_set(input logic [4:0] d);
    wb_valid = 1; wb_wen = 1; wb_wdest = d;
  endtask

  task automatic do_reset();
    idle();
    resetn = 0; model_reset();
    @(negedge clk); resetn = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle(); resetn = 0; model_reset();
    #2;
    n_chk++; if ({rs_wait, rt_wait, waw_full, id_stall, sb_err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000", {rs_wait, rt_wait, waw_full, id_stall, sb_err}); end
    n_chk++; if (inflight !== 3'd0) begin
      n_fail++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
    @(negedge clk); resetn = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_raw();
    idle(); issue_set(5); cyc();
    idle(); id_valid = 1; id_rs = 5; id_use_rs = 1; #1;
    n_chk++; if (rs_wait !== 1'b1 || id_stall !== 1'b1) begin
      n_fail++; $display("FAIL raw_wait: rs_wait=%b id_stall=%b want 1 1", rs_wait, id_stall); end
    n_chk++; if (inflight !== 3'd1) begin
      n_fail++; $display("FAIL raw_inflight: got %0d want 1", inflight); end
  endtask

  task automatic test_retire();
    retire_set(5); #1;
    n_chk++; if (rs_wait !== 1'b1) begin
      n_fail++; $display("FAIL retire_same_cycle: rs_wait=%b want 1", rs_wait); end
    cyc();
    wb_valid = 0; wb_wen = 0; wb_wdest = 0; #1;
    n_chk++; if (rs_wait !== 1'b0 || inflight !== 3'd0 || sb_err !== 1'b0) begin
      n_fail++; $display("FAIL retire_after: rs_wait=%b inflight=%0d sb_err=%b want 0 0 0", rs_wait, inflight, sb_err); end
  endtask

  task automatic test_waw();
    idle();
    repeat (3) begin issue_set(7); cyc(); end
    idle(); id_valid = 1; id_wen = 1; id_wdest = 7; #1;
    n_chk++; if (waw_full !== 1'b1 || id_stall !== 1'b1) begin
      n_fail++; $display("FAIL waw_full_set: waw_full=%b id_stall=%b want 1 1", waw_full, id_stall); end
    retire_set(7); cyc();
    wb_valid = 0; wb_wen = 0; wb_wdest = 0; #1;
    n_chk++; if (waw_full !== 1'b0 || id_stall !== 1'b0) begin
      n_fail++; $display("FAIL waw_full_clear: waw_full=%b id_stall=%b want 0 0", waw_full, id_stall); end
    id_fire = 1; cyc();
    idle(); retire_set(7);
    repeat (3) cyc();
    idle(); #1;
    n_chk++; if (inflight !== 3'd0 || sb_err !== 1'b0) begin
      n_fail++; $display("FAIL waw_drain: inflight=%0d sb_err=%b want 0 0", inflight, sb_err); end
  endtask

  task automatic test_same_cycle();
    idle(); issue_set(9); cyc();
    retire_set(9); cyc();
    idle(); id_valid = 1; id_rs = 9; id_use_rs = 1; #1;
    n_chk++; if (rs_wait !== 1'b1 || sb_err !== 1'b0 || inflight !== 3'd1) begin
      n_fail++; $display("FAIL same_cycle: rs_wait=%b sb_err=%b inflight=%0d want 1 0 1", rs_wait, sb_err, inflight); end
    idle(); retire_set(9); cyc();
    idle(); id_valid = 1; id_rs = 9; id_use_rs = 1; #1;
    n_chk++; if (rs_wait !== 1'b0 || inflight !== 3'd0) begin
      n_fail++; $display("FAIL same_cycle_drain: rs_wait=%b inflight=%0d want 0 0", rs_wait, inflight); end
  endtask

  task automatic test_flush();
    idle();
    issue_set(3); cyc(); cyc();
    issue_set(10); cyc();
    idle(); id_valid = 1; id_use_rt = 1; id_rt = 3; #1;
    n_chk++; if (rt_wait !== 1'b1 || inflight !== 3'd3) begin
      n_fail++; $display("FAIL flush_pre: rt_wait=%b inflight=%0d want 1 3", rt_wait, inflight); end
    flush = 1; retire_set(3); cyc();
    flush = 0; wb_valid = 0; wb_wen = 0; wb_wdest = 0; #1;
    n_chk++; if (rt_wait !== 1'b0 || inflight !== 3'd0 || sb_err !== 1'b0) begin
      n_fail++; $display("FAIL flush_post: rt_wait=%b inflight=%0d sb_err=%b want 0 0 0", rt_wait, inflight, sb_err); end
  endtask

  task automatic test_errors();
    idle(); issue_set(0); cyc();
    idle(); id_valid = 1; id_use_rs = 1; id_rs = 0; #1;
    n_chk++; if (rs_wait !== 1'b0) begin
      n_fail++; $display("FAIL r0_wait: rs_wait=%b want 0", rs_wait); end
    idle(); retire_set(0); cyc();
    idle(); retire_set(4); cyc();
    idle(); id_valid = 1; id_use_rs = 1; id_rs = 4; #1;
    n_chk++; if (sb_err !== 1'b1 || rs_wait !== 1'b0 || inflight !== 3'd0) begin
      n_fail++; $display("FAIL retire_empty: sb_err=%b rs_wait=%b inflight=%0d want 1 0 0", sb_err, rs_wait, inflight); end
    resetn = 0; model_reset(); #1;
    n_chk++; if (sb_err !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: sb_err=%b want 0", sb_err); end
    #2 resetn = 1;
    @(posedge clk); #1;
    idle(); id_fire = 1; id_wen = 1; id_wdest = 6; cyc();
    idle(); id_valid = 1; id_use_rs = 1; id_rs = 6; #1;
    n_chk++; if (sb_err !== 1'b1 || rs_wait !== 1'b0 || inflight !== 3'd0) begin
      n_fail++; $display("FAIL fire_no_valid: sb_err=%b rs_wait=%b inflight=%0d want 1 0 0", sb_err, rs_wait, inflight); end
  endtask

  task automatic test_random(input int cycles, input bit allow_bad);
    bit stall, fire;
    int head;
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      idle();
      id_valid  = ($urandom_range(0, 9) < 8);
      id_use_rs = $urandom_range(0, 1); id_rs = 5'($urandom_range(0, 7));
      id_use_rt = $urandom_range(0, 1); id_rt = 5'($urandom_range(0, 7));
      id_wen    = $urandom_range(0, 1);
      id_wdest  = id_wen ? 5'($urandom_range(0, 7)) : 5'd0;
      stall = e_rs() || e_rt() || e_waw();
      fire  = id_valid && !stall && q.size() < 7 && ($urandom_range(0, 9) < 7);
      if (allow_bad && $urandom_range(0, 19) == 0) fire = 1;
      id_fire = fire;
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        head = q[0];
        wb_valid = 1; wb_wen = (head > 0); wb_wdest = (head > 0) ? 5'(head) : 5'd0;
      end else if (allow_bad && $urandom_range(0, 29) == 0) begin
        wb_valid = 1; wb_wen = 1; wb_wdest = 5'($urandom_range(1, 7));
      end
      flush = ($urandom_range(0, 39) == 0);
      #1;
      n_chk++; if (rs_wait !== e_rs() || rt_wait !== e_rt() || waw_full !== e_waw()) begin
        n_fail++; $display("FAIL rand_waits c=%0d: rs=%b rt=%b waw=%b want %b %b %b",
          c, rs_wait, rt_wait, waw_full, e_rs(), e_rt(), e_waw()); end
      n_chk++; if (id_stall !== (e_rs() || e_rt() || e_waw())) begin
        n_fail++; $display("FAIL rand_stall c=%0d: got %b want %b", c, id_stall, e_rs() || e_rt() || e_waw()); end
      n_chk++; if (inflight !== 3'(m_inf) || sb_err !== m_err) begin
        n_fail++; $display("FAIL rand_state c=%0d: inflight=%0d sb_err=%b want %0d %b", c, inflight, sb_err, m_inf, m_err); end
      if (flush) q.delete();
      else begin
        if (wb_valid && q.size() > 0) void'(q.pop_front());
        if (id_fire && id_valid) q.push_back((id_wen && id_wdest != 0) ? int'(id_wdest) : -1);
      end
      cyc();
    end
  endtask

  initial begin
    idle(); resetn = 0; model_reset();
    test_reset();
    test_raw();
    test_retire();
    test_waw();
    test_same_cycle();
    test_flush();
    test_errors();
    test_random(400, 1'b0);
    test_random(400, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
